// File: rtl/csi2tx_nco_clk_gen_if.sv
// Control and clock-output bundle for csi2tx_nco_clk_gen.
// The master drives channel enables and increment configuration. The slave is the generator.
interface csi2tx_nco_clk_gen_if #(
  parameter int NCH   = 2,
  parameter int ACC_W = 16
);
  logic [NCH-1:0]       ch_en;
  logic [NCH-1:0]       cfg_vld;
  logic [NCH*ACC_W-1:0] cfg_inc;
  logic [NCH-1:0]       cfg_pend;
  logic [NCH-1:0]       clk_i_o;
  logic [NCH-1:0]       clk_q_o;
  logic [NCH-1:0]       tick_o;
  logic [NCH-1:0]       clk_generated;

  modport master (
    output ch_en, cfg_vld, cfg_inc,
    input  cfg_pend, clk_i_o, clk_q_o, tick_o, clk_generated
  );

  modport slave (
    input  ch_en, cfg_vld, cfg_inc,
    output cfg_pend, clk_i_o, clk_q_o, tick_o, clk_generated
  );
endinterface

// File: rtl/csi2tx_nco_clk_gen.sv
// N-channel NCO clock generator: each channel has a phase accumulator that produces I/Q clocks, a tick and a lock flag.
// Defining CLKGEN_QUAD_EN builds the quadrature output. Without it, clk_q_o is tied low.
module csi2tx_nco_clk_gen #(
  parameter int NCH      = 2,
  parameter int ACC_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic                hclk,
  input  logic                hrst,
  csi2tx_nco_clk_gen_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  localparam int               CNT_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] LOCK_V  = CNT_W'(LOCK_CNT);
  localparam logic [ACC_W-1:0] INC_MAX = {2'b01, {(ACC_W-2){1'b0}}};

  logic [NCH-1:0] pend_v;
  logic [NCH-1:0] clk_i_v;
  logic [NCH-1:0] clk_q_v;
  logic [NCH-1:0] tick_v;
  logic [NCH-1:0] gen_v;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pinc_q, pinc_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_i_q, clk_i_d;
    logic             tick_q, tick_d;
    logic             gen_q, gen_d;
    logic             lock_clr;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             en;
    logic             vld;
    logic [ACC_W-1:0] cfg_raw;
    logic [ACC_W-1:0] cfg_clamped;

    assign en      = bus.ch_en[k];
    assign vld     = bus.cfg_vld[k];
    assign cfg_raw = bus.cfg_inc[k*ACC_W +: ACC_W];
    // Capping at a quarter turn keeps f_out <= f_hclk/4, so every quadrant of clk_i/clk_q shows up.
    assign cfg_clamped = (cfg_raw > INC_MAX) ? INC_MAX : cfg_raw;
    assign sum         = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry       = sum[ACC_W];

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      inc_d    = inc_q;
      pinc_d   = pinc_q;
      pend_d   = pend_q;
      clk_i_d  = 1'b0;
      tick_d   = 1'b0;
      cnt_d    = cnt_q;
      gen_d    = 1'b0;
      lock_clr = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          acc_d = '0;
          if (pend_q) begin
            inc_d  = pinc_q;
            pend_d = 1'b0;
          end
          if (en && inc_d != '0) begin
            state_d = ST_RUN;
            acc_d   = inc_d;
          end
        end
        ST_RUN, ST_STOPPING: begin
          acc_d = sum[ACC_W-1:0];
          // A pending increment waits for the wrap, so the period in progress keeps its old length.
          if (carry && pend_q) begin
            inc_d  = pinc_q;
            pend_d = 1'b0;
          end
          if (en) begin
            state_d = ST_RUN;
          end else if (carry) begin
            state_d = ST_IDLE;
            acc_d   = '0;
          end else begin
            state_d = ST_STOPPING;
          end
          if (carry && inc_d == '0) begin
            state_d = ST_IDLE;
            acc_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
        end
      endcase

      // A capture in the same cycle as a wrap lands after the apply above, so it waits for the next wrap.
      if (vld) begin
        pinc_d = cfg_clamped;
        pend_d = 1'b1;
      end

      clk_i_d  = acc_d[ACC_W-1] ^ acc_d[ACC_W-2];
      tick_d   = clk_i_d & ~clk_i_q;
      lock_clr = vld | (state_q != ST_RUN) | (state_d != ST_RUN);
      if (lock_clr) begin
        cnt_d = '0;
      end else if (tick_q && cnt_q != LOCK_V) begin
        cnt_d = cnt_q + 1'b1;
      end
      gen_d = ~lock_clr & (cnt_d == LOCK_V);
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge hclk) begin
      if (hrst) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        inc_q   <= '0;
        pinc_q  <= '0;
        pend_q  <= 1'b0;
        cnt_q   <= '0;
        clk_i_q <= 1'b0;
        tick_q  <= 1'b0;
        gen_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        inc_q   <= inc_d;
        pinc_q  <= pinc_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
        clk_i_q <= clk_i_d;
        tick_q  <= tick_d;
        gen_q   <= gen_d;
      end
    end

`ifdef CLKGEN_QUAD_EN
    logic clk_q_q;
    always_ff @(posedge hclk) begin
      if (hrst) begin
        clk_q_q <= 1'b0;
      end else begin
        clk_q_q <= acc_d[ACC_W-1];
      end
    end
    assign clk_q_v[k] = clk_q_q;
`else
    assign clk_q_v[k] = 1'b0;
`endif

    assign pend_v[k]  = pend_q;
    assign clk_i_v[k] = clk_i_q;
    assign tick_v[k]  = tick_q;
    assign gen_v[k]   = gen_q;
  end

  assign bus.cfg_pend      = pend_v;
  assign bus.clk_i_o       = clk_i_v;
  assign bus.clk_q_o       = clk_q_v;
  assign bus.tick_o        = tick_v;
  assign bus.clk_generated = gen_v;
endmodule

// File: tb/tb_csi2tx_nco_clk_gen.sv
// Scoreboard bench for csi2tx_nco_clk_gen (NCH=2, ACC_W=16, LOCK_CNT=4).
// Each cycle a phase-arithmetic reference model queues the expected outputs, and a negedge monitor compares them.
module tb_csi2tx_nco_clk_gen;
  localparam int NCH   = 2;
  localparam int ACC_W = 16;
  localparam int TURN  = 65536;
  localparam int QTR   = 16384;
  localparam int LOCKN = 4;

  logic hclk = 1'b0;
  logic hrst = 1'b1;

  csi2tx_nco_clk_gen_if #(.NCH(NCH), .ACC_W(ACC_W)) bus ();

  csi2tx_nco_clk_gen #(.NCH(NCH), .ACC_W(ACC_W), .LOCK_CNT(LOCKN)) dut (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (bus)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [9:0] exp_q[$];

  // Reference model: phase as an integer in [0, TURN), with an "advancing" flag and a "draining" flag per channel.
  int m_acc[NCH];
  int m_inc[NCH];
  int m_pinc[NCH];
  int m_ticks[NCH];
  bit m_pend[NCH];
  bit m_adv[NCH];
  bit m_drain[NCH];
  bit m_clki[NCH];
  bit m_clkq[NCH];
  bit m_tick[NCH];
  bit m_lock[NCH];

  function automatic bit phase_i(int a);
    int qd;
    qd = a / QTR;
    return (qd == 1) || (qd == 2);
  endfunction

  function automatic bit phase_q(int a);
`ifdef CLKGEN_QUAD_EN
    return (a / QTR) >= 2;
`else
    return (a < 0);
`endif
  endfunction

  function automatic void model_step(bit rst, logic [1:0] en, logic [1:0] vld, logic [31:0] inc);
    for (int k = 0; k < NCH; k++) begin
      bit was_steady;
      bit old_clki;
      bit old_tick;
      bit wrapped;
      int raw;
      int nxt;
      if (rst) begin
        m_acc[k] = 0; m_inc[k] = 0; m_pinc[k] = 0; m_ticks[k] = 0;
        m_pend[k] = 0; m_adv[k] = 0; m_drain[k] = 0;
        m_clki[k] = 0; m_clkq[k] = 0; m_tick[k] = 0; m_lock[k] = 0;
        continue;
      end
      was_steady = m_adv[k] && !m_drain[k];
      old_clki   = m_clki[k];
      old_tick   = m_tick[k];
      raw        = int'(inc[k*ACC_W +: ACC_W]);
      if (!m_adv[k]) begin
        if (m_pend[k]) begin
          m_inc[k] = m_pinc[k];
          m_pend[k] = 0;
        end
        if (en[k] && m_inc[k] != 0) begin
          m_acc[k] = m_inc[k];
          m_adv[k] = 1;
          m_drain[k] = 0;
        end else begin
          m_acc[k] = 0;
        end
      end else begin
        nxt      = m_acc[k] + m_inc[k];
        wrapped  = nxt >= TURN;
        m_acc[k] = nxt % TURN;
        if (wrapped && m_pend[k]) begin
          m_inc[k] = m_pinc[k];
          m_pend[k] = 0;
        end
        if (en[k]) begin
          m_drain[k] = 0;
        end else if (wrapped) begin
          m_adv[k] = 0; m_drain[k] = 0; m_acc[k] = 0;
        end else begin
          m_drain[k] = 1;
        end
        if (wrapped && m_inc[k] == 0) begin
          m_adv[k] = 0; m_drain[k] = 0; m_acc[k] = 0;
        end
      end
      if (vld[k]) begin
        m_pinc[k] = (raw > QTR) ? QTR : raw;
        m_pend[k] = 1;
      end
      m_clki[k] = phase_i(m_acc[k]);
      m_clkq[k] = phase_q(m_acc[k]);
      m_tick[k] = m_clki[k] && !old_clki;
      if (vld[k] || !was_steady || !(m_adv[k] && !m_drain[k])) begin
        m_ticks[k] = 0;
        m_lock[k]  = 0;
      end else begin
        if (old_tick && m_ticks[k] < LOCKN) m_ticks[k]++;
        m_lock[k] = (m_ticks[k] == LOCKN);
      end
    end
  endfunction

  function automatic logic [9:0] model_out();
    return {m_pend[1], m_pend[0], m_clki[1], m_clki[0], m_clkq[1], m_clkq[0],
            m_tick[1], m_tick[0], m_lock[1], m_lock[0]};
  endfunction

  task automatic step(input bit rst, input logic [1:0] en, input logic [1:0] vld, input logic [31:0] inc);
    hrst        = rst;
    bus.ch_en   = en;
    bus.cfg_vld = vld;
    bus.cfg_inc = inc;
    @(posedge hclk);
    model_step(rst, en, vld, inc);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic run(input int n, input logic [1:0] en, input logic [31:0] inc);
    for (int i = 0; i < n; i++) step(1'b0, en, 2'b00, inc);
  endtask

  task automatic run_until_acc(input int k, input int val, input logic [1:0] en);
    for (int i = 0; i < 64 && m_acc[k] != val; i++) step(1'b0, en, 2'b00, 32'h0);
  endtask

  function automatic logic [15:0] pick_inc();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'h4000;
      2:       return 16'hFFFF;
      3:       return 16'h2000;
      4:       return 16'h1000;
      5:       return 16'($urandom_range(16'h4000, 16'h0800));
      6:       return 16'($urandom_range(16'hFFFF, 16'h4001));
      default: return 16'h0800;
    endcase
  endfunction

  initial begin : monitor
    logic [9:0] e;
    logic [9:0] a;
    forever begin
      @(negedge hclk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.cfg_pend, bus.clk_i_o, bus.clk_q_o, bus.tick_o, bus.clk_generated};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got={pend,i,q,tick,gen}=%b want=%b", cyc, a, e);
        end
      end
    end
  end

  initial begin : driver
    logic [1:0]  en;
    logic [1:0]  vld;
    logic [31:0] inc;
    bus.ch_en   = '0;
    bus.cfg_vld = '0;
    bus.cfg_inc = '0;

    // Reset with channels enabled and a live increment on the bus.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 2'b00, {16'h1000, 16'h1000});
    step(1'b0, 2'b11, 2'b00, {16'h1000, 16'h1000});

    // Start ch0 at a quarter-turn increment.
    step(1'b0, 2'b00, 2'b01, {16'h0000, 16'h4000});
    run(24, 2'b01, 32'h0);

    // Move to period 8, lock, then reconfigure to period 4 mid-period at acc=0x6000.
    step(1'b0, 2'b01, 2'b01, {16'h0000, 16'h2000});
    run(45, 2'b01, 32'h0);
    run_until_acc(0, 16'h6000, 2'b01);
    step(1'b0, 2'b01, 2'b01, {16'h0000, 16'h4000});
    run(30, 2'b01, 32'h0);

    // Disable mid-period at acc=0x4000 with inc=0x2000.
    step(1'b0, 2'b01, 2'b01, {16'h0000, 16'h2000});
    run(45, 2'b01, 32'h0);
    run_until_acc(0, 16'h4000, 2'b01);
    run(10, 2'b00, 32'h0);

    // Clamp on ch1, then a zero increment on ch1 (applied at the wrap) and on ch0 (idle).
    step(1'b0, 2'b00, 2'b10, {16'hFFFF, 16'h0000});
    run(24, 2'b10, 32'h0);
    step(1'b0, 2'b10, 2'b11, {16'h0000, 16'h0000});
    run(12, 2'b11, 32'h0);

    // Randomised traffic with back-to-back and carry-coincident reconfiguration.
    en = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      vld = 2'b00;
      inc = 32'h0;
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(39) == 0) en[k] = ~en[k];
        if ($urandom_range(19) == 0) begin
          vld[k] = 1'b1;
          inc[k*ACC_W +: ACC_W] = pick_inc();
        end
      end
      step(1'b0, en, vld, inc);
    end

    // Reset in the middle of operation aborts immediately.
    step(1'b0, 2'b11, 2'b11, {16'h4000, 16'h2000});
    run(12, 2'b11, 32'h0);
    step(1'b1, 2'b11, 2'b00, 32'h0);
    step(1'b1, 2'b11, 2'b00, 32'h0);
    run(3, 2'b11, 32'h0);

    @(negedge hclk);
    @(negedge hclk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending entries want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
